// File: rtl/bandai2003_unlock_host.sv
// bandai2003_unlock_host
// Console-side Bandai 2003 mapper unlock handshake. The block drives the
// 5Ah/A5h address pair and then deserialises the 16-bit command word that the
// cartridge returns on SO. If that word equals EXPECT_CMD, UNLOCKED is set.
// Optional build macro: SO_SYNC_EN. When defined, SO passes through a
// two-flop synchroniser, and HUNT tolerates TIMEOUT+2 idle samples.
module bandai2003_unlock_host #(
    parameter logic [15:0] EXPECT_CMD = 16'h28A0,
    parameter int          TIMEOUT    = 8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic        SO,
    output logic [7:0]  ADDR_O,
    output logic        BUS_REQ,
    output logic [15:0] CMD,
    output logic        CMD_VLD,
    output logic        UNLOCKED,
    output logic        ERR,
    output logic        BUSY
);

    typedef enum logic [2:0] {
        S_IDLE, S_ACK, S_NAK, S_HUNT, S_DATA, S_TAIL, S_ICHK
    } state_t;

    state_t state, nstate;
    logic   so_s;

`ifdef SO_SYNC_EN
    // The two synchroniser stages reach HUNT as extra idle-high samples
    localparam int HUNT_LIM = TIMEOUT + 2;
    logic [1:0] so_sync;

    // Two-flop synchroniser; resets to the idle (pulled-high) level
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) so_sync <= 2'b11;
        else     so_sync <= {so_sync[0], SO};
    end
    assign so_s = so_sync[1];
`else
    localparam int HUNT_LIM = TIMEOUT;
    assign so_s = SO;
`endif

    // One counter serves two purposes. In HUNT it counts idle samples.
    // In DATA it counts data bits.
    localparam int CW = ($clog2(HUNT_LIM + 1) > 4) ? $clog2(HUNT_LIM + 1) : 4;
    localparam logic [CW-1:0] HUNT_LAST = CW'(HUNT_LIM - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(15);

    logic [CW-1:0] cnt;
    logic [15:0]   sr;

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= S_IDLE;
        else     state <= nstate;
    end

    // Next-state logic
    always_comb begin
        nstate = state;
        case (state)
            S_IDLE: if (START && !UNLOCKED) nstate = S_ACK;
            S_ACK:  nstate = S_NAK;
            S_NAK:  nstate = S_HUNT;
            S_HUNT: begin
                if (!so_s)                 nstate = S_DATA;
                else if (cnt == HUNT_LAST) nstate = S_IDLE;
            end
            S_DATA: if (cnt == DATA_LAST) nstate = S_TAIL;
            S_TAIL: nstate = so_s ? S_IDLE : S_ICHK;
            S_ICHK: nstate = S_IDLE;
            default: nstate = S_IDLE;
        endcase
    end

    // Bus-side outputs decoded from state. Every non-sequence state
    // releases the bus with FFh.
    always_comb begin
        ADDR_O  = 8'hFF;
        BUS_REQ = 1'b0;
        BUSY    = (state != S_IDLE);
        case (state)
            S_ACK: begin ADDR_O = 8'h5A; BUS_REQ = 1'b1; end
            S_NAK: begin ADDR_O = 8'hA5; BUS_REQ = 1'b1; end
            default: ;
        endcase
    end

    // Datapath: counter, shift register, captured word and sticky flags
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt      <= '0;
            sr       <= '0;
            CMD      <= '0;
            CMD_VLD  <= 1'b0;
            UNLOCKED <= 1'b0;
            ERR      <= 1'b0;
        end else begin
            CMD_VLD <= 1'b0;
            case (state)
                S_IDLE: if (START && !UNLOCKED) ERR <= 1'b0;
                S_ACK:  cnt <= '0;
                S_HUNT: begin
                    if (!so_s)                 cnt <= '0;
                    else if (cnt == HUNT_LAST) ERR <= 1'b1;
                    else                       cnt <= cnt + CW'(1);
                end
                S_DATA: begin
                    sr  <= {so_s, sr[15:1]};
                    cnt <= cnt + CW'(1);
                end
                S_TAIL: if (so_s) ERR <= 1'b1;
                S_ICHK: begin
                    if (!so_s) begin
                        ERR <= 1'b1;
                    end else begin
                        CMD     <= sr;
                        CMD_VLD <= 1'b1;
                        if (sr == EXPECT_CMD) UNLOCKED <= 1'b1;
                        else                  ERR      <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bandai2003_unlock_host.sv
// Testbench for bandai2003_unlock_host. A cartridge model replays bit
// streams after it sees the 5Ah/A5h address pair. Expected outcomes come
// from a stream-level reference model.
module tb_bandai2003_unlock_host;

    localparam int          TO  = 8;
    localparam logic [15:0] EXP = 16'h28A0;
`ifdef SO_SYNC_EN
    localparam int SL = 2;
`else
    localparam int SL = 0;
`endif

    logic        CLK = 1'b0;
    logic        RST, START, SO;
    logic [7:0]  ADDR_O;
    logic        BUS_REQ;
    logic [15:0] CMD;
    logic        CMD_VLD, UNLOCKED, ERR, BUSY;

    int          nvec = 0;
    int          nerr = 0;
    logic [15:0] cmd_m = '0;
    bit          unl_m = 1'b0;

    bandai2003_unlock_host #(.EXPECT_CMD(EXP), .TIMEOUT(TO)) dut (
        .CLK(CLK), .RST(RST), .START(START), .SO(SO),
        .ADDR_O(ADDR_O), .BUS_REQ(BUS_REQ), .CMD(CMD), .CMD_VLD(CMD_VLD),
        .UNLOCKED(UNLOCKED), .ERR(ERR), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Stream bit j; the line floats high past the end
    function automatic bit sb(input bit [63:0] s, input int j);
        return (j < 64) ? s[j] : 1'b1;
    endfunction

    // Build a stream: h idle ones, start 0, word LSB first, tail bit, idle bit
    function automatic bit [63:0] mk(input logic [15:0] w, input int h, input bit tl, input bit id);
        bit [63:0] s = '1;
        s[h] = 1'b0;
        for (int b = 0; b < 16; b++) s[h+1+b] = w[b];
        s[h+17] = tl;
        s[h+18] = id;
        return s;
    endfunction

    // Reference outcome of one sequence. Stream sample j is taken at edge e(3+j+SL).
    task automatic model(input bit [63:0] s, output int done, output bit vld,
                         output logic [15:0] w, output bit err, output bit unl);
        int h = 0;
        vld = 0; err = 0; unl = 0; w = '0;
        while (h < TO && sb(s, h)) h++;
        if (h == TO) begin
            done = TO + 2 + SL; err = 1; return;
        end
        for (int b = 0; b < 16; b++) w[b] = sb(s, h + 1 + b);
        done = 3 + h + 18 + SL;
        if (sb(s, h + 17) != 1'b0) begin done = 3 + h + 17 + SL; err = 1; return; end
        if (sb(s, h + 18) != 1'b1) begin err = 1; return; end
        vld = 1;
        if (w == EXP) unl = 1; else err = 1;
    endtask

    task automatic check_rst(input string tag);
        chk({tag, "/addr"},  ADDR_O,   8'hFF);
        chk({tag, "/busreq"}, BUS_REQ, 0);
        chk({tag, "/cmd"},   CMD,      0);
        chk({tag, "/vld"},   CMD_VLD,  0);
        chk({tag, "/unl"},   UNLOCKED, 0);
        chk({tag, "/err"},   ERR,      0);
        chk({tag, "/busy"},  BUSY,     0);
    endtask

    // Pulse START, act as the cartridge, and check the observed trace against
    // the model. rep >= 0 re-pulses START after edge rep. rst_at >= 0 asserts RST after that edge.
    task automatic run(input bit [63:0] s, input int rep, input int rst_at);
        int          done, nv, vk, pos;
        bit          vld, err, unl, load, act, ok_addr, ok_busy;
        logic [15:0] w;
        logic [7:0]  prev, ea;
        model(s, done, vld, w, err, unl);
        nv = 0; vk = -1; pos = 0; load = 0; act = 0; ok_addr = 1; ok_busy = 1;
        prev = 8'hFF;
        START = 1'b1;
        for (int k = 0; k <= done + 2; k++) begin
            tick();
            START = (k == rep);
            if (load) begin act = 1; pos = 0; load = 0; end
            if (act) begin SO = sb(s, pos); pos++; end
            if (ADDR_O == 8'hA5 && prev == 8'h5A) load = 1;
            prev = ADDR_O;
            if (k == rst_at) begin
                RST = 1'b1;
                #1;
                check_rst("midrst");
                cmd_m = '0; unl_m = 0; SO = 1'b1; START = 1'b0;
                tick();
                RST = 1'b0;
                tick();
                return;
            end
            ea = (k == 0) ? 8'h5A : (k == 1) ? 8'hA5 : 8'hFF;
            if (ADDR_O !== ea || BUS_REQ !== (k < 2)) ok_addr = 0;
            if (BUSY !== (k < done)) ok_busy = 0;
            if (CMD_VLD === 1'b1) begin nv++; vk = k; end
        end
        SO = 1'b1;
        if (vld) cmd_m = w;
        unl_m = unl_m | unl;
        chk("addr_seq", ok_addr, 1);
        chk("busy",     ok_busy, 1);
        chk("vld_cnt",  nv,      vld);
        if (vld) chk("vld_edge", vk, done);
        chk("cmd",      CMD,      cmd_m);
        chk("err",      ERR,      err);
        chk("unlocked", UNLOCKED, unl_m);
    endtask

    initial begin
        bit          ok;
        logic [15:0] w;
        int          h, mode;
        bit [63:0]   s;
        RST = 1'b1; START = 1'b0; SO = 1'b1;
        tick(); tick();
        check_rst("reset");
        RST = 1'b0;
        tick();

        run('1, -1, -1);                          // cartridge never answers
        run(mk(16'h1234, 0, 0, 1), -1, -1);       // well framed, wrong word
        run(mk(EXP, 0, 1, 1), -1, -1);            // tail corrupted
        run(mk(EXP, 0, 0, 0), -1, -1);            // idle bit corrupted

        for (int i = 0; i < 24; i++) begin
            w = 16'($urandom);
            if (w == EXP) w = w ^ 16'h0001;
            h    = $urandom_range(0, TO - 1);
            mode = $urandom_range(0, 3);
            s    = (mode == 3) ? '1 : mk(w, h, mode == 1, mode != 2);
            run(s, -1, -1);
        end

        run(mk(EXP, 0, 0, 1), -1, 8);             // RST during DATA
        run(mk(EXP, 0, 0, 1), 8, -1);             // full unlock, START re-pulsed in DATA

        // START after unlock must be ignored
        ok = 1;
        START = 1'b1;
        for (int k = 0; k < 7; k++) begin
            tick();
            START = 1'b0;
            if (BUSY !== 1'b0 || ADDR_O !== 8'hFF || BUS_REQ !== 1'b0) ok = 0;
        end
        chk("ign_start", ok, 1);
        chk("unl_hold",  UNLOCKED, 1);
        chk("cmd_hold",  CMD, EXP);
        chk("err_hold",  ERR, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
